path_stack: RTL and testbench
=============================

# path_stack

Location stack and path-replay stage for the maze solver datapath.
- The solving controller pushes each visited cell's 8-bit location while advancing and pops on backtrack; this block holds the current route.
- Once the controller reports success, the stored route is replayed start-to-destination over a valid/ready stream to the downstream path display/consumer.
- It is the storage stage directly beside the controller: it produces the controller's `empStck` input and consumes its `push`/`pop`.

## Interface
- `DEPTH`, default 256: stack entries; power of two, ≥ 2.
- `W`, default 8: location width, {row[3:0], col[3:0]}.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-low reset, sampled on `clk` rising edge.
- `push`  in  1: write `dIn` on top of the stack.
- `pop`  in  1: remove the top entry.
- `dIn`  in  W: location to push.
- `run`  in  1: request replay of the stored route; level, held by the source.
- `pathRdy`  in  1: downstream ready.
- `top`  out  W: the entry at `sp-1`; 0 when empty.
- `empStck`  out  1: stack empty.
- `full`  out  1: `sp == DEPTH`.
- `pathOut`  out  W: replayed location.
- `pathVld`  out  1: `pathOut` is valid.
- `replayDone`  out  1: all entries have been emitted.
- `ovf`  out  1: sticky overflow flag (see Configuration).

## Operation
- Storage is a `DEPTH`×`W` register array with stack pointer `sp` of width log2(DEPTH)+1.
  - `sp` counts entries and ranges 0..DEPTH.
  - Read pointer `rp` has the same width.
- FSM states and transitions:
  - IDLE → REPLAY when `run` = 1 and `sp` ≠ 0.
  - IDLE → FIN when `run` = 1 and `sp` = 0.
  - REPLAY → FIN on the handshake of entry `sp-1`.
  - FIN → IDLE when `run` = 0.
- IDLE behaviour:
  - `push` alone, not full: `mem[sp] <= dIn`, `sp <= sp+1`.
  - `pop` alone, not empty: `sp <= sp-1`; the popped slot's contents are don't-care.
  - `push` and `pop` together, not empty: replace the top, `mem[sp-1] <= dIn`; `sp` is unchanged.
  - `push` and `pop` together, empty: treated as a push.
  - `pop` while empty is ignored; `sp` stays 0.
  - `push` while full is ignored; see Configuration for `ovf`.
- REPLAY behaviour:
  - `rp` starts at 0, the bottom entry, which is the start cell.
  - `pathOut = mem[rp]` and `pathVld = 1`.
  - When `pathVld & pathRdy`, `rp <= rp+1`.
  - `push`/`pop` are ignored; the contents are frozen.
  - `pathOut` is stable while `pathVld & ~pathRdy`.
- FIN behaviour:
  - `replayDone = 1`, `pathVld = 0`.
  - `sp` is retained, so a second `run` rising after return to IDLE replays the same route again.
- `rst` low, in any state and at any point mid-replay:
  - next edge: state IDLE, `sp = 0`, `rp = 0`, `ovf = 0`.
  - Array contents are not cleared.
- Reset values of outputs: `top` 0, `empStck` 1, `full` 0, `pathOut` 0, `pathVld` 0, `replayDone` 0, `ovf` 0.

## Timing
- Push/pop take effect at the sampling edge.
  - `empStck`, `full` and `top` are combinational from `sp`/array, so they reflect the new state in the following cycle.
  - The controller may push and then pop on consecutive cycles.
- `top` is a combinational read of `mem[sp-1]`, zero-latency after the edge.
- Replay latency:
  - `run` sampled in IDLE gives `pathVld` = 1 in the next cycle.
  - At full throughput, one entry per cycle while `pathRdy` = 1.
- Completion: `replayDone` rises the cycle after the last handshake and stays high while `run` = 1.
- `pathOut` is registered from `mem[rp]` (registered `rp`, mux read); there is no combinational path from `pathRdy` to `pathOut`.

## Configuration
- `PATH_STACK_OVF_EN` defined:
  - A push while full (without a simultaneous pop) sets `ovf` = 1.
  - `ovf` is sticky until reset.
  - While `ovf` = 1, `run` goes IDLE → FIN immediately with `replayDone` = 1 and emits nothing, because the route is corrupt.
- Not defined:
  - `ovf` is tied to 0.
  - A push while full is silently dropped.
  - Replay proceeds normally on the `DEPTH` stored entries.

## Test plan
- Reset, then push 0x00, 0x01, 0x11:
  - `top` = 0x11, `empStck` = 0.
  - Then `pop`: `top` = 0x01.
  - Then push and pop together with `dIn` = 0x12: `top` = 0x12, `sp` = 2.
- Empty stack, `pop` pulse: `sp` stays 0, `empStck` = 1. Then `run` = 1: `replayDone` = 1 the next cycle, `pathVld` never asserted.
- Push 0x00, 0x10, 0x20, 0xFF, then `run` with `pathRdy` = 1:
  - `pathOut` = 0x00, 0x10, 0x20, 0xFF on four consecutive cycles.
  - `replayDone` = 1 on the cycle after 0xFF.
- Same route with `pathRdy` toggling 1,0,0,1,1,0,1:
  - Each value is held while ready is low.
  - Order is unchanged; `push` asserted during replay does not alter `sp`.
- With `DEPTH` = 4: push 5 values.
  - `full` = 1 after 4 pushes; `sp` = 4.
  - With the macro: `ovf` = 1 and `run` gives an immediate `replayDone`.
  - Without the macro: `ovf` = 0 and replay emits the first 4 values.
- Mid-replay, after 2 of 4 handshakes, pull `rst` low for one edge: next cycle `pathVld` = 0, `empStck` = 1, `replayDone` = 0, state IDLE.

Source files
------------

// File: rtl/path_stack.sv
// path_stack: location stack for the maze controller, replayed bottom-to-top over valid/ready.
// Optional: define PATH_STACK_OVF_EN for a sticky overflow flag that suppresses replay.
module path_stack #(
    parameter int DEPTH = 256,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] dIn,
    input  logic         run,
    input  logic         pathRdy,
    output logic [W-1:0] top,
    output logic         empStck,
    output logic         full,
    output logic [W-1:0] pathOut,
    output logic         pathVld,
    output logic         replayDone,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REPLAY, FIN} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   sp_reg, sp_next;
    logic [AW:0]   rp_reg, rp_next;
    logic [W-1:0]  path_out_reg;
    logic          is_empty, is_full, handshake, last_entry, ovf_flag;
    logic          wr_en, load_out;
    logic [AW-1:0] wr_addr, top_addr;

    assign is_empty   = (sp_reg == '0);
    assign is_full    = (sp_reg == FULL_CNT);
    assign handshake  = (state_reg == REPLAY) && pathRdy;
    assign last_entry = (rp_reg == sp_reg - ONE);
    assign top_addr   = AW'(sp_reg - ONE);

`ifdef PATH_STACK_OVF_EN
    logic ovf_reg, ovf_next;

    always_comb begin
        ovf_next = ovf_reg;
        if (state_reg == IDLE && push && !pop && is_full)
            ovf_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) ovf_reg <= 1'b0;
        else      ovf_reg <= ovf_next;
    end

    assign ovf_flag = ovf_reg;
`else
    assign ovf_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // An overflowed route is corrupt, so replay is skipped straight to FIN.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (run) state_next = (is_empty || ovf_flag) ? FIN : REPLAY;
            REPLAY:  if (handshake && last_entry) state_next = FIN;
            FIN:     if (!run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pathVld    = 1'b0;
        replayDone = 1'b0;
        unique case (state_reg)
            REPLAY:  pathVld    = 1'b1;
            FIN:     replayDone = 1'b1;
            default: ;
        endcase
    end

    // Push/pop only act in IDLE; a simultaneous push+pop replaces the top entry.
    always_comb begin
        sp_next = sp_reg;
        wr_en   = 1'b0;
        wr_addr = sp_reg[AW-1:0];
        if (state_reg == IDLE) begin
            if (push && pop && !is_empty) begin
                wr_en   = 1'b1;
                wr_addr = top_addr;
            end else if (push && !is_full) begin
                wr_en   = 1'b1;
                sp_next = sp_reg + ONE;
            end else if (pop && !push && !is_empty) begin
                sp_next = sp_reg - ONE;
            end
        end
    end

    always_comb begin
        rp_next  = rp_reg;
        load_out = 1'b0;
        if (state_reg == IDLE && state_next == REPLAY) begin
            rp_next  = '0;
            load_out = 1'b1;
        end else if (handshake) begin
            rp_next  = rp_reg + ONE;
            load_out = !last_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_reg       <= '0;
            rp_reg       <= '0;
            path_out_reg <= '0;
        end else begin
            sp_reg <= sp_next;
            rp_reg <= rp_next;
            if (load_out)
                path_out_reg <= mem[rp_next[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en)
            mem[wr_addr] <= dIn;
    end

    assign top     = is_empty ? '0 : mem[top_addr];
    assign empStck = is_empty;
    assign full    = is_full;
    assign pathOut = path_out_reg;
    assign ovf     = ovf_flag;

endmodule

// File: tb/tb_path_stack.sv
// tb_path_stack: directed and randomized checks of path_stack against a queue-based route model.
`timescale 1ns/1ps
module tb_path_stack;
    localparam int DEPTH = 4;
    localparam int W     = 8;

    logic         clk = 1'b0;
    logic         rst, push, pop, run, pathRdy;
    logic [W-1:0] dIn, top, pathOut;
    logic         empStck, full, pathVld, replayDone, ovf;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] stk[$];
    bit ovf_m  = 1'b0;
    bit ovf_en = 1'b0;

    always #5 clk = ~clk;

    path_stack #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .dIn(dIn), .run(run),
        .pathRdy(pathRdy), .top(top), .empStck(empStck), .full(full),
        .pathOut(pathOut), .pathVld(pathVld), .replayDone(replayDone), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stack(input string tag);
        logic [W-1:0] exp_top;
        exp_top = (stk.size() > 0) ? stk[stk.size()-1] : '0;
        chk({tag, "_top"},   32'(top),     32'(exp_top));
        chk({tag, "_empty"}, 32'(empStck), 32'(stk.size() == 0));
        chk({tag, "_full"},  32'(full),    32'(stk.size() == DEPTH));
        chk({tag, "_ovf"},   32'(ovf),     32'(ovf_m));
    endtask

    task automatic idle_op(input bit p, input bit q, input logic [W-1:0] d);
        push = p; pop = q; dIn = d; run = 1'b0;
        tick();
        push = 1'b0; pop = 1'b0;
        if (p && q && stk.size() > 0)      stk[stk.size()-1] = d;
        else if (p && stk.size() < DEPTH)  stk.push_back(d);
        else if (p && !q)                  ovf_m = ovf_m | ovf_en;
        else if (q && stk.size() > 0)      void'(stk.pop_back());
        $display("op push=%0b pop=%0b din=%02h entries=%0d", p, q, d, stk.size());
        check_stack("op");
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1,1,0,1, 2: random ready
    task automatic do_replay(input int mode);
        logic [W-1:0] exp_q[$];
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        int idx, cyc, n;
        bit rdy, skip;
        exp_q = stk;
        n     = stk.size();
        skip  = ovf_m || (n == 0);
        pathRdy = 1'b0; push = 1'b0; pop = 1'b0; run = 1'b1;
        tick();
        chk("rp_vld_first",  32'(pathVld),    32'(!skip));
        chk("rp_done_first", 32'(replayDone), 32'(skip));
        idx = 0; cyc = 0;
        while (!skip && idx < n && cyc < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (pat[cyc % 7] != 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            pathRdy = rdy;
            push = 1'($urandom_range(0, 1));
            pop  = 1'($urandom_range(0, 1));
            dIn  = W'($urandom);
            chk("rp_vld", 32'(pathVld), 32'd1);
            chk("rp_out", 32'(pathOut), 32'(exp_q[idx]));
            tick();
            if (rdy) idx++;
            cyc++;
        end
        push = 1'b0; pop = 1'b0; pathRdy = 1'b0;
        if (!skip && idx < n) chk("rp_timeout", 32'(idx), 32'(n));
        $display("replay mode=%0d entries=%0d cycles=%0d", mode, n, cyc);
        chk("rp_done",      32'(replayDone), 32'd1);
        chk("rp_vld_end",   32'(pathVld),    32'd0);
        tick();
        chk("rp_done_hold", 32'(replayDone), 32'd1);
        run = 1'b0;
        tick();
        chk("rp_done_clr",  32'(replayDone), 32'd0);
        check_stack("after_rp");
    endtask

    task automatic do_reset();
        rst = 1'b0; push = 1'b0; pop = 1'b0; run = 1'b0; pathRdy = 1'b0; dIn = '0;
        tick();
        rst = 1'b1;
        stk.delete();
        ovf_m = 1'b0;
        $display("reset");
    endtask

    initial begin
`ifdef PATH_STACK_OVF_EN
        ovf_en = 1'b1;
`endif
        rst = 1'b0; push = 1'b0; pop = 1'b0; run = 1'b0; pathRdy = 1'b0; dIn = '0;
        tick();
        tick();
        rst = 1'b1;
        chk("rst_top",     32'(top),        32'h0);
        chk("rst_empty",   32'(empStck),    32'd1);
        chk("rst_full",    32'(full),       32'd0);
        chk("rst_pathout", 32'(pathOut),    32'h0);
        chk("rst_vld",     32'(pathVld),    32'd0);
        chk("rst_done",    32'(replayDone), 32'd0);
        chk("rst_ovf",     32'(ovf),        32'd0);

        // push / pop / replace
        idle_op(1, 0, 8'h00);
        idle_op(1, 0, 8'h01);
        idle_op(1, 0, 8'h11);
        chk("t1_top",   32'(top),     32'h11);
        chk("t1_empty", 32'(empStck), 32'd0);
        idle_op(0, 1, 8'h00);
        chk("t1_pop_top", 32'(top), 32'h01);
        idle_op(1, 1, 8'h12);
        chk("t1_repl_top", 32'(top), 32'h12);
        do_replay(0);

        // empty pop and empty replay
        do_reset();
        idle_op(0, 1, 8'h00);
        chk("t2_empty", 32'(empStck), 32'd1);
        do_replay(0);

        // full-throughput replay, then throttled replay of the same route
        do_reset();
        idle_op(1, 0, 8'h00);
        idle_op(1, 0, 8'h10);
        idle_op(1, 0, 8'h20);
        idle_op(1, 0, 8'hFF);
        do_replay(0);
        do_replay(1);

        // overflow at DEPTH = 4
        chk("t4_full", 32'(full), 32'd1);
        idle_op(1, 0, 8'h44);
        chk("t4_ovf", 32'(ovf), 32'(ovf_en));
        do_replay(0);

        // reset in the middle of a replay
        do_reset();
        idle_op(1, 0, 8'hA0);
        idle_op(1, 0, 8'hA1);
        idle_op(1, 0, 8'hA2);
        idle_op(1, 0, 8'hA3);
        run = 1'b1; pathRdy = 1'b1;
        tick();
        chk("t5_out0", 32'(pathOut), 32'hA0);
        tick();
        chk("t5_out1", 32'(pathOut), 32'hA1);
        tick();
        rst = 1'b0; run = 1'b0; pathRdy = 1'b0;
        tick();
        rst = 1'b1;
        stk.delete();
        ovf_m = 1'b0;
        chk("t5_vld",   32'(pathVld),    32'd0);
        chk("t5_empty", 32'(empStck),    32'd1);
        chk("t5_done",  32'(replayDone), 32'd0);
        idle_op(1, 0, 8'h33);

        // randomized sessions
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            for (int k = 0; k < int'($urandom_range(1, 8)); k++)
                idle_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
            do_replay(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
